flash_req_bridge: RTL and testbench

- Upstream stage of the SPI flash controller (SPIFlashModule); replaces the free-running test stimulus in the flash top level with a CPU-facing request/response port.
- Accepts one 32-bit word read or write request at a time and drives the controller's en/write/addr/data_in.
- Waits for the controller's ready, captures data_out, and returns a response with error reporting for misalignment, write protection and timeout.

---
 rtl/flash_req_bridge.sv | 141 ++++++++++++++
 tb/tb_flash_req_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_req_bridge.sv
// CPU request/response front end for the SPI flash controller: one word op at a time,
// with alignment/write-protect rejection, WAIT timeout and an enforced CS-recovery gap.
module flash_req_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CNT_W          = 21,
   parameter logic [23:0] PROTECT_TOP    = 24'h1FFFFF,
   parameter int unsigned GAP_CYCLES     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic        cpu_req_write,
   input  logic [23:0] cpu_req_addr,
   input  logic [31:0] cpu_req_wdata,
   output logic        cpu_resp_valid,
   input  logic        cpu_resp_ready,
   output logic [31:0] cpu_resp_rdata,
   output logic        cpu_resp_err,
   output logic        flash_en,
   output logic        flash_write,
   output logic [23:0] flash_addr,
   output logic [31:0] flash_data_in,
   input  logic [31:0] flash_data_out,
   input  logic        flash_ready,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      GAP_PRE,
      GAP,
      RESP
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] to_cnt;
   logic [3:0]       gap_cnt;
   logic             req_bad;

   assign req_bad = (cpu_req_addr[1:0] != 2'b00) ||
                    (cpu_req_write && (cpu_req_addr <= PROTECT_TOP));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= GAP;
         gap_cnt        <= GAP_LOAD;
         to_cnt         <= '0;
         cpu_req_ready  <= 1'b0;
         cpu_resp_valid <= 1'b0;
         cpu_resp_rdata <= '0;
         cpu_resp_err   <= 1'b0;
         flash_en       <= 1'b0;
         flash_write    <= 1'b0;
         flash_addr     <= '0;
         flash_data_in  <= '0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req_valid) begin
                  cpu_req_ready <= 1'b0;
                  busy          <= 1'b1;
                  if (req_bad) begin
                     state          <= RESP;
                     cpu_resp_valid <= 1'b1;
                     cpu_resp_err   <= 1'b1;
                     cpu_resp_rdata <= '0;
                  end else begin
                     state         <= ISSUE;
                     flash_en      <= 1'b1;
                     flash_write   <= cpu_req_write;
                     flash_addr    <= cpu_req_addr;
                     flash_data_in <= cpu_req_wdata;
                  end
               end
            end

            ISSUE: begin
               to_cnt <= '0;
               state  <= WAIT;
            end

            WAIT: begin
               // ready is checked before the timeout so a same-cycle ready still succeeds
               if (flash_ready || (to_cnt == TO_LAST)) begin
                  state          <= GAP_PRE;
                  gap_cnt        <= GAP_LOAD;
                  flash_en       <= 1'b0;
                  flash_write    <= 1'b0;
                  flash_addr     <= '0;
                  flash_data_in  <= '0;
                  cpu_resp_err   <= !flash_ready;
                  cpu_resp_rdata <= (flash_ready && !flash_write) ? flash_data_out : '0;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end

            GAP_PRE, GAP: begin
               // gap_cnt holds the low cycles still owed, including the current one
               if (gap_cnt <= 4'd1) begin
                  if (state == GAP_PRE) begin
                     state          <= RESP;
                     cpu_resp_valid <= 1'b1;
                  end else begin
                     state         <= IDLE;
                     cpu_req_ready <= 1'b1;
                     busy          <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
                  busy    <= 1'b1;
               end
            end

            RESP: begin
               if (cpu_resp_ready) begin
                  state          <= IDLE;
                  cpu_resp_valid <= 1'b0;
                  cpu_resp_err   <= 1'b0;
                  cpu_resp_rdata <= '0;
                  cpu_req_ready  <= 1'b1;
                  busy           <= 1'b0;
               end
            end

            default: begin
               state   <= GAP;
               gap_cnt <= GAP_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flash_req_bridge.sv
// Bench for flash_req_bridge: directed and random ops against an arithmetic model of
// acceptance, timeout, latency and response contents, plus async reset behaviour.
module tb_flash_req_bridge;

   localparam int unsigned TO    = 64;
   localparam int unsigned GAP   = 4;
   localparam int unsigned CNT_W = 21;
   localparam logic [23:0] PROT  = 24'h1FFFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_ready;
   logic        cpu_req_write = 1'b0;
   logic [23:0] cpu_req_addr = '0;
   logic [31:0] cpu_req_wdata = '0;
   logic        cpu_resp_valid;
   logic        cpu_resp_ready = 1'b0;
   logic [31:0] cpu_resp_rdata;
   logic        cpu_resp_err;
   logic        flash_en;
   logic        flash_write;
   logic [23:0] flash_addr;
   logic [31:0] flash_data_in;
   logic [31:0] flash_data_out = '0;
   logic        flash_ready = 1'b0;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_fall_cyc = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flash_req_bridge #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W(CNT_W),
      .PROTECT_TOP(PROT),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cpu_req_valid(cpu_req_valid),
      .cpu_req_ready(cpu_req_ready),
      .cpu_req_write(cpu_req_write),
      .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid),
      .cpu_resp_ready(cpu_resp_ready),
      .cpu_resp_rdata(cpu_resp_rdata),
      .cpu_resp_err(cpu_resp_err),
      .flash_en(flash_en),
      .flash_write(flash_write),
      .flash_addr(flash_addr),
      .flash_data_in(flash_data_in),
      .flash_data_out(flash_data_out),
      .flash_ready(flash_ready),
      .busy(busy)
   );

   task automatic chk(input string op, input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%h expected=%h", op, tag, obs, exp);
      end
   endtask

   // n = WAIT cycle (1-based) in which the controller raises ready; 0 = never
   task automatic do_op(input string nm, input logic wr, input logic [23:0] addr,
                        input logic [31:0] wd, input int unsigned n,
                        input logic [31:0] rd, input int unsigned hold);
      logic        rej, tmo, err_exp, seen, ok, prev_en;
      logic [31:0] rdata_exp, r0;
      logic        e0;
      int unsigned neff, en_exp, t_exp, t, en_cnt;

      rej       = (addr[1:0] != 2'b00) || (wr && (addr <= PROT));
      tmo       = !rej && ((n == 0) || (n > TO));
      neff      = tmo ? TO : n;
      en_exp    = rej ? 0 : 1 + neff;
      t_exp     = rej ? 1 : 2 + neff + GAP;
      err_exp   = rej || tmo;
      rdata_exp = (!err_exp && !wr) ? rd : 32'h0;

      chk(nm, "req_ready_idle", 32'(cpu_req_ready), 32'd1);
      cpu_req_valid = 1'b1;
      cpu_req_write = wr;
      cpu_req_addr  = addr;
      cpu_req_wdata = wd;
      @(negedge clk);
      cpu_req_valid = 1'b0;
      cpu_req_write = 1'($urandom);
      cpu_req_addr  = 24'($urandom);
      cpu_req_wdata = $urandom;

      t = 1; en_cnt = 0; seen = 1'b0; ok = 1'b1; prev_en = 1'b0;
      while (!seen && t <= 200) begin
         if (cpu_resp_valid) begin
            seen = 1'b1;
         end else begin
            if (cpu_req_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            flash_ready = 1'b0;
            if (flash_en) begin
               if (en_cnt == 0 && last_fall_cyc >= 0)
                  chk(nm, "en_gap_ge_min", 32'((cyc - last_fall_cyc) >= int'(GAP)), 32'd1);
               en_cnt++;
               if (flash_write !== wr || flash_addr !== addr || (wr && flash_data_in !== wd))
                  ok = 1'b0;
               if (en_cnt == 1) flash_ready = 1'($urandom);
               else if (en_cnt - 1 == n) flash_ready = 1'b1;
            end else begin
               if (prev_en) last_fall_cyc = cyc;
               flash_ready = 1'($urandom);
            end
            flash_data_out = (flash_en && en_cnt >= 2 && flash_ready) ? rd : $urandom;
            prev_en = flash_en;
            @(negedge clk);
            t++;
         end
      end
      flash_ready = 1'b0;

      chk(nm, "resp_seen", 32'(seen), 32'd1);
      chk(nm, "resp_latency", t, t_exp);
      chk(nm, "en_high_cycles", en_cnt, en_exp);
      chk(nm, "op_outputs_stable", 32'(ok), 32'd1);

      r0 = cpu_resp_rdata; e0 = cpu_resp_err; ok = 1'b1;
      repeat (hold) begin
         if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== r0 || cpu_resp_err !== e0 ||
             cpu_req_ready !== 1'b0 || flash_en !== 1'b0) ok = 1'b0;
         flash_ready = 1'($urandom);
         @(negedge clk);
      end
      flash_ready = 1'b0;
      chk(nm, "resp_hold_stable", 32'(ok), 32'd1);
      chk(nm, "resp_rdata", cpu_resp_rdata, rdata_exp);
      chk(nm, "resp_err", 32'(cpu_resp_err), 32'(err_exp));

      cpu_resp_ready = 1'b1;
      @(negedge clk);
      cpu_resp_ready = 1'b0;
      chk(nm, "post_req_ready", 32'(cpu_req_ready), 32'd1);
      chk(nm, "post_resp_valid", 32'(cpu_resp_valid), 32'd0);
      chk(nm, "post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned k;
      logic        wr;
      logic [23:0] a;
      int unsigned n, sel;

      // reset state, checked before the first clock edge and again while held
      reset = 1'b0;
      #3;
      chk("reset", "outs_zero",
          32'({cpu_req_ready, cpu_resp_valid, cpu_resp_err, flash_en, flash_write, busy}), 32'd0);
      chk("reset", "data_zero", cpu_resp_rdata | flash_data_in | 32'(flash_addr), 32'd0);
      repeat (2) @(negedge clk);
      chk("reset", "held_outs_zero", 32'({cpu_req_ready, cpu_resp_valid, flash_en, busy}), 32'd0);
      reset = 1'b1;
      k = 0;
      while (!cpu_req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("reset", "req_ready_delay", k, GAP);

      do_op("read", 1'b0, 24'h0F0F0C, 32'h0, 40, 32'hDEADBEEF, 0);
      do_op("write", 1'b1, 24'h666664, 32'h12345678, 17, 32'hA5A5A5A5, 1);
      do_op("rej_prot", 1'b1, 24'h000100, 32'hCAFEF00D, 5, 32'h1111_1111, 0);
      do_op("rej_mis", 1'b0, 24'h999999, 32'h0, 5, 32'h2222_2222, 0);
      do_op("tmo_never", 1'b0, 24'h300000, 32'h0, 0, 32'h3333_3333, 0);
      do_op("ready_on_last", 1'b0, 24'h300004, 32'h0, TO, 32'h0BADF00D, 0);
      do_op("tmo_late", 1'b0, 24'h300008, 32'h0, TO + 1, 32'h4444_4444, 0);
      do_op("wr_prot_edge", 1'b1, 24'h1FFFFC, 32'h5555_5555, 3, 32'h0, 0);
      do_op("wr_above_prot", 1'b1, 24'h200000, 32'h6666_6666, 3, 32'h0, 0);
      do_op("rd_prot_region", 1'b0, 24'h000100, 32'h0, 1, 32'h7777_7777, 0);
      do_op("b2b_a", 1'b0, 24'h123454, 32'h0, 8, 32'h89ABCDEF, 10);
      do_op("b2b_b", 1'b1, 24'h800000, 32'h0F1E2D3C, 2, 32'h0, 10);

      for (int i = 0; i < 24; i++) begin
         wr  = 1'($urandom);
         a   = 24'($urandom);
         sel = $urandom_range(0, 3);
         if (sel != 0) a[1:0] = 2'b00;
         if (sel == 1 && wr) a = a & 24'h1FFFFC;
         case ($urandom_range(0, 7))
            0:       n = 0;
            1:       n = TO;
            2:       n = TO + 1;
            default: n = $urandom_range(1, 50);
         endcase
         do_op("random", wr, a, $urandom, n, $urandom, $urandom_range(0, 3));
      end

      // asynchronous reset in the middle of WAIT
      chk("async_rst", "req_ready_before", 32'(cpu_req_ready), 32'd1);
      cpu_req_valid = 1'b1;
      cpu_req_write = 1'b0;
      cpu_req_addr  = 24'h400000;
      @(negedge clk);
      cpu_req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("async_rst", "en_in_wait", 32'(flash_en), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst", "en_dropped", 32'(flash_en), 32'd0);
      chk("async_rst", "busy_dropped", 32'(busy), 32'd0);
      chk("async_rst", "resp_valid_low", 32'(cpu_resp_valid), 32'd0);
      chk("async_rst", "req_ready_low", 32'(cpu_req_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      last_fall_cyc = -1;
      k = 0;
      while (!cpu_req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("async_rst", "req_ready_delay", k, GAP);
      chk("async_rst", "no_stale_resp", 32'(cpu_resp_valid), 32'd0);
      do_op("after_rst", 1'b0, 24'h400010, 32'h0, 6, 32'h13579BDF, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
